// File: rtl/btn_step_gen_pkg.sv
// Shared types and defaults for the front-panel step generator.
package btn_step_gen_pkg;

  // FSM encoding; values are fixed so debug taps and waveforms stay stable.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DEB     = 3'd1,
    ST_HOLD    = 3'd2,
    ST_REPEAT  = 3'd3,
    ST_RELEASE = 3'd4
  } state_e;

  // Default timing for a 100 MHz clk: 10 ms debounce, 500 ms hold, 100 ms repeat.
  localparam int unsigned DEF_CNT_W         = 26;
  localparam int unsigned DEF_DEB_CYCLES    = 1_000_000;
  localparam int unsigned DEF_HOLD_CYCLES   = 50_000_000;
  localparam int unsigned DEF_REPEAT_CYCLES = 10_000_000;

  // Button vector layout: req = {up, dn}.
  localparam int NUM_BTN = 2;

  // Single-button request pattern for a latched direction.
  function automatic logic [NUM_BTN-1:0] dir_pattern(input logic up);
    return up ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/btn_step_gen_sync_2ff.sv
// Two-flop synchroniser for one asynchronous button pin.
module btn_step_gen_sync_2ff (
  input  logic clk,
  input  logic rs_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops; async clear so reset never depends on clk.
  always_ff @(posedge clk or negedge rs_n) begin
    if (!rs_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/btn_step_gen.sv
// Debounced two-button step source with hold-to-repeat, driving counter en/up.
module btn_step_gen
  import btn_step_gen_pkg::*;
#(
  parameter int unsigned CNT_W         = DEF_CNT_W,
  parameter int unsigned DEB_CYCLES    = DEF_DEB_CYCLES,
  parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic rs_n,
  input  logic btn_up,
  input  logic btn_dn,
  input  logic repeat_en,
  output logic step_en,
  output logic step_up,
  output logic repeating
);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  logic [NUM_BTN-1:0] raw, req;
  state_e             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               dir_up, dir_nxt;
  logic               pulse;
  logic               match, valid;

  assign raw = {btn_up, btn_dn};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_sync
    btn_step_gen_sync_2ff u_sync (
      .clk  (clk),
      .rs_n (rs_n),
      .d    (raw[i]),
      .q    (req[i])
    );
  end

  assign valid = (req == 2'b10) || (req == 2'b01);
  assign match = (req == dir_pattern(dir_up));

  // Next state / counter / pulse decision. Mismatch is tested before any
  // pulse condition so a release on the due edge suppresses the step.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CNT_W'(1);
    dir_nxt   = dir_up;
    pulse     = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (valid) begin
          state_nxt = ST_DEB;
          dir_nxt   = req[1];
        end
      end
      ST_DEB: begin
        if (!match) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == DEB_LAST) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = '0;
          pulse     = 1'b1;
        end
      end
      ST_HOLD: begin
        if (!match) begin
          state_nxt = ST_RELEASE;
          cnt_nxt   = '0;
        end else if (!repeat_en) begin
          cnt_nxt = '0;
        end else if (cnt == HOLD_LAST) begin
          state_nxt = ST_REPEAT;
          cnt_nxt   = '0;
          pulse     = 1'b1;
        end
      end
      ST_REPEAT: begin
        if (!match) begin
          state_nxt = ST_RELEASE;
          cnt_nxt   = '0;
        end else if (cnt == REP_LAST) begin
          cnt_nxt = '0;
          pulse   = 1'b1;
        end
      end
      ST_RELEASE: begin
        // Any activity restarts the quiet window; both pins must be idle.
        if (req != '0) begin
          cnt_nxt = '0;
        end else if (cnt == DEB_LAST) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State, timing counter and registered outputs.
  always_ff @(posedge clk or negedge rs_n) begin
    if (!rs_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      dir_up    <= 1'b0;
      step_en   <= 1'b0;
      step_up   <= 1'b0;
      repeating <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      dir_up    <= dir_nxt;
      step_en   <= pulse;
      if (pulse) step_up <= dir_up;
      repeating <= (state_nxt == ST_REPEAT);
    end
  end

endmodule

// File: tb/tb_btn_step_gen.sv
// Directed bench for btn_step_gen with short timing (DEB=4, HOLD=10, REPEAT=5).
// Edge index 0 is the first posedge that samples the newly driven pin level;
// a pulse at index k means step_en is seen high just after edge k.
module tb_btn_step_gen;

  logic clk = 1'b0;
  logic rs_n, btn_up, btn_dn, repeat_en;
  logic step_en, step_up, repeating;

  int tests = 0;
  int fails = 0;
  int ecnt  = 0;
  int base  = 0;
  int np;
  int pidx[16];
  int pup[16];
  int rep_first, rep_last, consec;
  logic prev_en;

  always #5 clk = ~clk;

  always @(posedge clk) ecnt <= ecnt + 1;

  btn_step_gen #(
    .CNT_W         (8),
    .DEB_CYCLES    (4),
    .HOLD_CYCLES   (10),
    .REPEAT_CYCLES (5)
  ) u_dut (
    .clk       (clk),
    .rs_n      (rs_n),
    .btn_up    (btn_up),
    .btn_dn    (btn_dn),
    .repeat_en (repeat_en),
    .step_en   (step_en),
    .step_up   (step_up),
    .repeating (repeating)
  );

  task automatic chk(input string tag, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Open a new observation window; call at a negedge before driving pins.
  task automatic win_start();
    base = ecnt;
    np   = 0;
    for (int i = 0; i < 16; i++) begin
      pidx[i] = -1;
      pup[i]  = -1;
    end
    rep_first = -1;
    rep_last  = -1;
    consec    = 0;
    prev_en   = 1'b0;
  endtask

  // Advance n cycles, logging pulses and the repeating interval.
  task automatic run(input int n);
    int idx;
    repeat (n) begin
      @(negedge clk);
      idx = ecnt - base - 1;
      if (step_en === 1'b1) begin
        if (np < 16) begin
          pidx[np] = idx;
          pup[np]  = (step_up === 1'b1) ? 1 : 0;
        end
        np++;
        if (prev_en) consec++;
      end
      prev_en = step_en;
      if (repeating === 1'b1) begin
        if (rep_first < 0) rep_first = idx;
        rep_last = idx;
      end
    end
  endtask

  initial begin
    rs_n = 1'b0; btn_up = 1'b0; btn_dn = 1'b0; repeat_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_step_en",   step_en,   0);
    chk("rst_step_up",   step_up,   0);
    chk("rst_repeating", repeating, 0);
    rs_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: up held 12 samples; released before the hold period expires.
    win_start(); btn_up = 1'b1; run(12); btn_up = 1'b0; run(20);
    chk("t1_count", np, 1);
    chk("t1_edge",  pidx[0], 6);
    chk("t1_dir",   pup[0], 1);
    chk("t1_norep", rep_first, -1);
    chk("t1_hold_dir", step_up, 1);

    // 2: down held 38 samples with auto-repeat; repeat_en drops mid-REPEAT
    // and must not stop the pulses. Release is seen by the FSM at edge 40.
    win_start(); btn_dn = 1'b1; run(20); repeat_en = 1'b0; run(18);
    btn_dn = 1'b0; run(20); repeat_en = 1'b1;
    chk("t2_count", np, 6);
    chk("t2_e0", pidx[0], 6);
    chk("t2_e1", pidx[1], 16);
    chk("t2_e2", pidx[2], 21);
    chk("t2_e3", pidx[3], 26);
    chk("t2_e4", pidx[4], 31);
    chk("t2_e5", pidx[5], 36);
    chk("t2_dir0", pup[0], 0);
    chk("t2_dir5", pup[5], 0);
    chk("t2_rep_first", rep_first, 16);
    chk("t2_rep_last",  rep_last, 39);
    chk("t2_consec", consec, 0);
    chk("t2_hold_dir", step_up, 0);

    // 3: 3-sample glitch is dropped; a press must span DEB_CYCLES+1 samples.
    win_start(); btn_up = 1'b1; run(3); btn_up = 1'b0; run(10);
    chk("t3_glitch", np, 0);
    win_start(); btn_up = 1'b1; run(5); btn_up = 1'b0; run(15);
    chk("t3_count", np, 1);
    chk("t3_edge",  pidx[0], 6);

    // 4a: both buttons together never step.
    win_start(); btn_up = 1'b1; btn_dn = 1'b1; run(20);
    btn_up = 1'b0; btn_dn = 1'b0; run(10);
    chk("t4_both", np, 0);
    // 4b: second button added while holding, then a 2-cycle release gap:
    // only the original up pulse, RELEASE quiet count restarts.
    win_start(); btn_up = 1'b1; run(8); btn_dn = 1'b1; run(10);
    btn_dn = 1'b0; run(10); btn_up = 1'b0; run(2); btn_up = 1'b1; run(12);
    btn_up = 1'b0; run(12);
    chk("t4_count", np, 1);
    chk("t4_edge",  pidx[0], 6);
    chk("t4_dir",   pup[0], 1);
    chk("t4_norep", rep_first, -1);
    // 4c: after a full quiet release the block re-arms.
    win_start(); btn_up = 1'b1; run(12); btn_up = 1'b0; run(12);
    chk("t4_rearm_count", np, 1);
    chk("t4_rearm_edge",  pidx[0], 6);

    // 5: repeat disabled -> single pulse for a long hold.
    repeat_en = 1'b0;
    win_start(); btn_up = 1'b1; run(30); btn_up = 1'b0; run(12);
    chk("t5_count", np, 1);
    chk("t5_edge",  pidx[0], 6);
    chk("t5_norep", rep_first, -1);
    repeat_en = 1'b1;

    // 6: reset while a pulse is on the output clears it at once; with the
    // button still held the press is timed afresh from reset release.
    win_start(); btn_up = 1'b1; run(7);
    chk("t6_pre_pulse", step_en, 1);
    rs_n = 1'b0;
    #1;
    chk("t6_rst_step_en",   step_en,   0);
    chk("t6_rst_step_up",   step_up,   0);
    chk("t6_rst_repeating", repeating, 0);
    repeat (2) @(negedge clk);
    rs_n = 1'b1;
    win_start(); run(12); btn_up = 1'b0; run(12);
    chk("t6_count", np, 1);
    chk("t6_edge",  pidx[0], 6);
    chk("t6_dir",   pup[0], 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
